// File: rtl/snake_tick_sequencer.sv
// Movement-tick scheduler for the snake datapath: length-dependent tick period,
// filtered direction latch, and the move -> check -> apple step handshake.
`timescale 1ns/1ps

module snake_tick_sequencer #(
    parameter int unsigned TICK_DIV    = 16666666,
    parameter int unsigned MIN_DIV     = 4166666,
    parameter int unsigned SPEED_STEP  = 200000,
    parameter int unsigned SPEED_SHIFT = 2,
    parameter int unsigned CNT_W       = 25
) (
    input  logic        board_clk,
    input  logic        Reset,
    input  logic        run,
    input  logic        dir_valid,
    input  logic [1:0]  dir_in,
    input  logic [7:0]  length_in,
    input  logic        move_ack,
    input  logic        collision_in,
    input  logic        ate_in,
    input  logic        apple_ack,
    output logic [1:0]  dir_cur,
    output logic        move_req,
    output logic        apple_req,
    output logic        halted,
    output logic        overrun,
    output logic [15:0] step_count
);

    // state     | meaning
    // IDLE      | game not running, counter parked at base period
    // WAIT_TICK | counting down to the next movement tick
    // MOVE      | move_req raised, waiting for move_ack
    // CHECK     | one cycle to act on captured collision / ate
    // APPLE     | apple_req raised, waiting for apple_ack
    // HALT      | collision seen, counter frozen until run drops
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_TICK = 3'd1,
        S_MOVE      = 3'd2,
        S_CHECK     = 3'd3,
        S_APPLE     = 3'd4,
        S_HALT      = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_BASE = CNT_W'(TICK_DIV - 1);
    localparam logic [1:0]       DIR_RIGHT = 2'b11;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       pend_q, pend_d;
    logic [1:0]       dir_q, dir_d;
    logic             col_q, col_d;
    logic             ate_q, ate_d;
    logic             move_req_q, move_req_d;
    logic             apple_req_q, apple_req_d;
    logic             halted_q, halted_d;
    logic             overrun_q, overrun_d;
    logic [15:0]      steps_q, steps_d;

    logic [31:0]      level_w;
    logic [31:0]      reduce_w;
    logic [31:0]      period_w;
    logic [CNT_W-1:0] period_cnt;
    logic             tick;
    logic             dir_reversal;

    // Reduction is computed wide so that an oversized length clamps instead of wrapping.
    always_comb begin
        level_w  = 32'(length_in >> SPEED_SHIFT);
        reduce_w = level_w * SPEED_STEP;
        if (reduce_w >= TICK_DIV) begin
            period_w = MIN_DIV;
        end else if ((TICK_DIV - reduce_w) < MIN_DIV) begin
            period_w = MIN_DIV;
        end else begin
            period_w = TICK_DIV - reduce_w;
        end
    end

    assign period_cnt   = CNT_W'(period_w);
    assign tick         = run && (cnt_q == '0) &&
                          (state_q inside {S_WAIT_TICK, S_MOVE, S_CHECK, S_APPLE});
    assign dir_reversal = (dir_in[1] == dir_q[1]) && (dir_in != dir_q);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_d    = pend_q;
        dir_d     = dir_q;
        col_d     = col_q;
        ate_d     = ate_q;
        overrun_d = overrun_q;
        steps_d   = steps_q;

        if (!run) begin
            state_d   = S_IDLE;
            cnt_d     = CNT_BASE;
            pend_d    = DIR_RIGHT;
            dir_d     = DIR_RIGHT;
            col_d     = 1'b0;
            ate_d     = 1'b0;
            overrun_d = 1'b0;
            steps_d   = 16'd0;
        end else begin
            if (state_q == S_IDLE) begin
                cnt_d = period_cnt;
            end else if (state_q != S_HALT) begin
                cnt_d = (cnt_q == '0) ? (period_cnt - CNT_ONE) : (cnt_q - CNT_ONE);
            end

            if (dir_valid && (state_q != S_IDLE) && (state_q != S_HALT) && !dir_reversal) begin
                pend_d = dir_in;
            end

            // Ticks landing mid-step are dropped, only flagged.
            if (tick && (state_q != S_WAIT_TICK)) begin
                overrun_d = 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    state_d = S_WAIT_TICK;
                end
                S_WAIT_TICK: begin
                    if (tick) begin
                        state_d = S_MOVE;
                        dir_d   = pend_q;
                    end
                end
                S_MOVE: begin
                    if (move_ack) begin
                        col_d   = collision_in;
                        ate_d   = ate_in;
                        state_d = S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (col_q) begin
                        state_d = S_HALT;
                    end else if (ate_q) begin
                        state_d = S_APPLE;
                    end else begin
                        state_d = S_WAIT_TICK;
                        steps_d = steps_q + 16'd1;
                    end
                end
                S_APPLE: begin
                    if (apple_ack) begin
                        state_d = S_WAIT_TICK;
                        steps_d = steps_q + 16'd1;
                    end
                end
                S_HALT: begin
                    state_d = S_HALT;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        move_req_d  = (state_d == S_MOVE);
        apple_req_d = (state_d == S_APPLE);
        halted_d    = (state_d == S_HALT);
    end

    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= CNT_BASE;
            pend_q      <= DIR_RIGHT;
            dir_q       <= DIR_RIGHT;
            col_q       <= 1'b0;
            ate_q       <= 1'b0;
            move_req_q  <= 1'b0;
            apple_req_q <= 1'b0;
            halted_q    <= 1'b0;
            overrun_q   <= 1'b0;
            steps_q     <= 16'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            dir_q       <= dir_d;
            col_q       <= col_d;
            ate_q       <= ate_d;
            move_req_q  <= move_req_d;
            apple_req_q <= apple_req_d;
            halted_q    <= halted_d;
            overrun_q   <= overrun_d;
            steps_q     <= steps_d;
        end
    end

    assign dir_cur    = dir_q;
    assign move_req   = move_req_q;
    assign apple_req  = apple_req_q;
    assign halted     = halted_q;
    assign overrun    = overrun_q;
    assign step_count = steps_q;

endmodule

// File: tb/tb_snake_tick_sequencer.sv
// Directed bench for snake_tick_sequencer with a short base period (8 cycles).
`timescale 1ns/1ps

module tb_snake_tick_sequencer;

    logic        board_clk = 1'b0;
    logic        Reset;
    logic        run;
    logic        dir_valid;
    logic [1:0]  dir_in;
    logic [7:0]  length_in;
    logic        move_ack;
    logic        collision_in;
    logic        ate_in;
    logic        apple_ack;
    logic [1:0]  dir_cur;
    logic        move_req;
    logic        apple_req;
    logic        halted;
    logic        overrun;
    logic [15:0] step_count;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    snake_tick_sequencer #(
        .TICK_DIV(8), .MIN_DIV(4), .SPEED_STEP(1), .SPEED_SHIFT(2), .CNT_W(8)
    ) dut (
        .board_clk(board_clk), .Reset(Reset), .run(run), .dir_valid(dir_valid),
        .dir_in(dir_in), .length_in(length_in), .move_ack(move_ack),
        .collision_in(collision_in), .ate_in(ate_in), .apple_ack(apple_ack),
        .dir_cur(dir_cur), .move_req(move_req), .apple_req(apple_req),
        .halted(halted), .overrun(overrun), .step_count(step_count)
    );

    initial forever #5 board_clk = ~board_clk;

    always @(posedge board_clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge board_clk);
        #1;
    endtask

    task automatic restart(input logic [7:0] len);
        run = 1'b0;
        step();
        step();
        length_in = len;
        run = 1'b1;
        step();
    endtask

    task automatic press(input logic [1:0] d);
        dir_in = d;
        dir_valid = 1'b1;
        step();
        dir_valid = 1'b0;
    endtask

    task automatic wait_req(output int n, output bit got);
        n = 0;
        while (move_req !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        got = (move_req === 1'b1);
    endtask

    // Waits for move_req, answers after 'delay' cycles, then lets CHECK resolve.
    task automatic move_step(input int delay, input logic col, input logic ate,
                             output int n, output bit got, output int rise);
        wait_req(n, got);
        rise = cyc;
        repeat (delay) step();
        collision_in = col;
        ate_in = ate;
        move_ack = 1'b1;
        step();
        move_ack = 1'b0;
        collision_in = 1'b0;
        ate_in = 1'b0;
        step();
    endtask

    task automatic test_reset();
        vectors++; if (dir_cur !== 2'b11) begin miscompares++; $display("FAIL reset_dir: got %b want 11", dir_cur); end
        vectors++; if (move_req !== 1'b0) begin miscompares++; $display("FAIL reset_move_req: got %b want 0", move_req); end
        vectors++; if (apple_req !== 1'b0) begin miscompares++; $display("FAIL reset_apple_req: got %b want 0", apple_req); end
        vectors++; if (halted !== 1'b0) begin miscompares++; $display("FAIL reset_halted: got %b want 0", halted); end
        vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL reset_overrun: got %b want 0", overrun); end
        vectors++; if (step_count !== 16'd0) begin miscompares++; $display("FAIL reset_steps: got %0d want 0", step_count); end
    endtask

    task automatic test_base_period();
        int n; bit got; int r1, r2, r3;
        restart(8'd3);
        move_step(2, 1'b0, 1'b0, n, got, r1);
        vectors++; if (!got || n != 9) begin miscompares++; $display("FAIL base_first_req: got %0d cycles (seen=%0d) want 9", n, got); end
        vectors++; if (step_count !== 16'd1) begin miscompares++; $display("FAIL base_steps1: got %0d want 1", step_count); end
        move_step(2, 1'b0, 1'b0, n, got, r2);
        vectors++; if (!got || (r2 - r1) != 8) begin miscompares++; $display("FAIL base_spacing1: got %0d want 8", r2 - r1); end
        vectors++; if (step_count !== 16'd2) begin miscompares++; $display("FAIL base_steps2: got %0d want 2", step_count); end
        move_step(2, 1'b0, 1'b0, n, got, r3);
        vectors++; if (!got || (r3 - r2) != 8) begin miscompares++; $display("FAIL base_spacing2: got %0d want 8", r3 - r2); end
        vectors++; if (step_count !== 16'd3) begin miscompares++; $display("FAIL base_steps3: got %0d want 3", step_count); end
        vectors++; if (dir_cur !== 2'b11) begin miscompares++; $display("FAIL base_dir: got %b want 11", dir_cur); end
        vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL base_overrun: got %b want 0", overrun); end
    endtask

    task automatic test_speed_periods();
        int n; bit got; int r1, r2;
        restart(8'd12);
        move_step(0, 1'b0, 1'b0, n, got, r1);
        vectors++; if (!got || n != 6) begin miscompares++; $display("FAIL speed12_first: got %0d want 6", n); end
        move_step(0, 1'b0, 1'b0, n, got, r2);
        vectors++; if (!got || (r2 - r1) != 5) begin miscompares++; $display("FAIL speed12_spacing: got %0d want 5", r2 - r1); end
        restart(8'd40);
        move_step(0, 1'b0, 1'b0, n, got, r1);
        vectors++; if (!got || n != 5) begin miscompares++; $display("FAIL speed40_first: got %0d want 5", n); end
        move_step(0, 1'b0, 1'b0, n, got, r2);
        vectors++; if (!got || (r2 - r1) != 4) begin miscompares++; $display("FAIL speed40_spacing: got %0d want 4", r2 - r1); end
        restart(8'd20);
        move_step(0, 1'b0, 1'b0, n, got, r1);
        move_step(0, 1'b0, 1'b0, n, got, r2);
        vectors++; if (!got || (r2 - r1) != 4) begin miscompares++; $display("FAIL speed20_spacing: got %0d want 4", r2 - r1); end
    endtask

    task automatic test_direction();
        int n; bit got; int r;
        restart(8'd3);
        press(2'b10);
        move_step(0, 1'b0, 1'b0, n, got, r);
        vectors++; if (dir_cur !== 2'b11) begin miscompares++; $display("FAIL dir_reversal_left: got %b want 11", dir_cur); end
        press(2'b00);
        press(2'b01);
        vectors++; if (dir_cur !== 2'b11) begin miscompares++; $display("FAIL dir_before_commit: got %b want 11", dir_cur); end
        move_step(0, 1'b0, 1'b0, n, got, r);
        vectors++; if (dir_cur !== 2'b01) begin miscompares++; $display("FAIL dir_last_press: got %b want 01", dir_cur); end
        press(2'b00);
        move_step(0, 1'b0, 1'b0, n, got, r);
        vectors++; if (dir_cur !== 2'b01) begin miscompares++; $display("FAIL dir_reversal_up: got %b want 01", dir_cur); end
        press(2'b11);
        move_step(0, 1'b0, 1'b0, n, got, r);
        vectors++; if (dir_cur !== 2'b11) begin miscompares++; $display("FAIL dir_turn_right: got %b want 11", dir_cur); end
    endtask

    task automatic test_apple();
        int n; bit got; int r1, r2; bit held;
        restart(8'd3);
        move_step(0, 1'b0, 1'b1, n, got, r1);
        vectors++; if (apple_req !== 1'b1) begin miscompares++; $display("FAIL apple_req_rise: got %b want 1", apple_req); end
        vectors++; if (step_count !== 16'd0) begin miscompares++; $display("FAIL apple_steps_pending: got %0d want 0", step_count); end
        held = 1'b1;
        repeat (4) begin
            step();
            if (apple_req !== 1'b1) held = 1'b0;
        end
        vectors++; if (held !== 1'b1) begin miscompares++; $display("FAIL apple_req_hold: got dropped want held"); end
        apple_ack = 1'b1;
        step();
        apple_ack = 1'b0;
        vectors++; if (apple_req !== 1'b0) begin miscompares++; $display("FAIL apple_req_drop: got %b want 0", apple_req); end
        vectors++; if (step_count !== 16'd1) begin miscompares++; $display("FAIL apple_steps: got %0d want 1", step_count); end
        vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL apple_overrun: got %b want 0", overrun); end
        move_step(0, 1'b0, 1'b0, n, got, r2);
        vectors++; if (!got || (r2 - r1) != 8) begin miscompares++; $display("FAIL apple_spacing: got %0d want 8", r2 - r1); end
        vectors++; if (step_count !== 16'd2) begin miscompares++; $display("FAIL apple_steps2: got %0d want 2", step_count); end
        move_ack = 1'b1; collision_in = 1'b1; ate_in = 1'b1; apple_ack = 1'b1;
        step();
        move_ack = 1'b0; collision_in = 1'b0; ate_in = 1'b0; apple_ack = 1'b0;
        step();
        vectors++; if (halted !== 1'b0) begin miscompares++; $display("FAIL stray_ack_halted: got %b want 0", halted); end
        vectors++; if (apple_req !== 1'b0 || move_req !== 1'b0) begin miscompares++; $display("FAIL stray_ack_reqs: got apple=%b move=%b want 0 0", apple_req, move_req); end
        vectors++; if (step_count !== 16'd2) begin miscompares++; $display("FAIL stray_ack_steps: got %0d want 2", step_count); end
        move_step(0, 1'b0, 1'b0, n, got, r1);
        vectors++; if (!got || step_count !== 16'd3) begin miscompares++; $display("FAIL stray_ack_next: got %0d want 3", step_count); end
    endtask

    task automatic test_overrun();
        int n; bit got; int r1, r2;
        restart(8'd3);
        move_step(12, 1'b0, 1'b0, n, got, r1);
        vectors++; if (overrun !== 1'b1) begin miscompares++; $display("FAIL overrun_set: got %b want 1", overrun); end
        vectors++; if (step_count !== 16'd1) begin miscompares++; $display("FAIL overrun_steps: got %0d want 1", step_count); end
        vectors++; if (move_req !== 1'b0) begin miscompares++; $display("FAIL overrun_no_queue0: got %b want 0", move_req); end
        step();
        vectors++; if (move_req !== 1'b0) begin miscompares++; $display("FAIL overrun_no_queue1: got %b want 0", move_req); end
        move_step(0, 1'b0, 1'b0, n, got, r2);
        vectors++; if (!got || (r2 - r1) != 16) begin miscompares++; $display("FAIL overrun_next_tick: got %0d want 16", r2 - r1); end
        vectors++; if (overrun !== 1'b1) begin miscompares++; $display("FAIL overrun_sticky: got %b want 1", overrun); end
        run = 1'b0;
        step();
        vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL overrun_clear: got %b want 0", overrun); end
    endtask

    task automatic test_halt();
        int n; bit got; int r; bit quiet;
        restart(8'd3);
        press(2'b00);
        move_step(0, 1'b0, 1'b0, n, got, r);
        vectors++; if (dir_cur !== 2'b00) begin miscompares++; $display("FAIL halt_dir_up: got %b want 00", dir_cur); end
        move_step(0, 1'b1, 1'b0, n, got, r);
        vectors++; if (halted !== 1'b1) begin miscompares++; $display("FAIL halt_set: got %b want 1", halted); end
        quiet = 1'b1;
        repeat (20) begin
            step();
            if (move_req !== 1'b0 || apple_req !== 1'b0 || halted !== 1'b1) quiet = 1'b0;
        end
        vectors++; if (quiet !== 1'b1) begin miscompares++; $display("FAIL halt_quiet: got activity want none"); end
        vectors++; if (step_count !== 16'd1) begin miscompares++; $display("FAIL halt_steps: got %0d want 1", step_count); end
        run = 1'b0;
        step();
        vectors++; if (halted !== 1'b0) begin miscompares++; $display("FAIL halt_clear: got %b want 0", halted); end
        vectors++; if (step_count !== 16'd0) begin miscompares++; $display("FAIL halt_steps_clear: got %0d want 0", step_count); end
        vectors++; if (dir_cur !== 2'b11) begin miscompares++; $display("FAIL halt_dir_clear: got %b want 11", dir_cur); end
    endtask

    task automatic test_reset_mid_move();
        int n; bit got; int r;
        restart(8'd3);
        move_step(0, 1'b0, 1'b0, n, got, r);
        wait_req(n, got);
        vectors++; if (!got) begin miscompares++; $display("FAIL midmove_req: got none want move_req"); end
        Reset = 1'b1;
        run = 1'b0;
        #1;
        vectors++; if (move_req !== 1'b0) begin miscompares++; $display("FAIL midmove_async_drop: got %b want 0", move_req); end
        vectors++; if (step_count !== 16'd0) begin miscompares++; $display("FAIL midmove_steps: got %0d want 0", step_count); end
        step();
        Reset = 1'b0;
        step();
    endtask

    initial begin
        Reset = 1'b1; run = 1'b0; dir_valid = 1'b0; dir_in = 2'b00; length_in = 8'd3;
        move_ack = 1'b0; collision_in = 1'b0; ate_in = 1'b0; apple_ack = 1'b0;
        step();
        step();
        test_reset();
        Reset = 1'b0;
        step();
        test_base_period();
        test_speed_periods();
        test_direction();
        test_apple();
        test_overrun();
        test_halt();
        test_reset_mid_move();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/snake_tick_sequencer.md
Name: snake_tick_sequencer

Overview:
Game-step scheduler for the snake datapath. It produces the movement tick from board_clk with a programmable, length-dependent period. It filters and latches direction presses, then sequences each step as: commit direction, move request/ack, outcome check, and an optional apple-regeneration request/ack. It sits between the debounced direction buttons / state machine and the length/apple modules, replacing the free-running divided-clock speed source.

Parameters:
TICK_DIV, 16666666, base tick period in board_clk cycles (~6 Hz at 100 MHz)
MIN_DIV, 4166666, minimum tick period (clamp)
SPEED_STEP, 200000, period reduction per speed level
SPEED_SHIFT, 2, speed level = length_in >> SPEED_SHIFT
CNT_W, 25, tick counter width; must hold TICK_DIV-1

Ports:
board_clk  in  1  system clock
Reset  in  1  reset, asynchronous, active-high
run  in  1  game running (q_Run); low forces IDLE
dir_valid  in  1  one-cycle direction press strobe
dir_in  in  2  pressed direction: 00 up, 01 down, 10 left, 11 right
length_in  in  8  current snake length
move_ack  in  1  length module finished the head/tail update
collision_in  in  1  collision result, valid while move_ack high
ate_in  in  1  apple eaten, valid while move_ack high
apple_ack  in  1  apple module placed a new apple
dir_cur  out  2  committed direction for the current step
move_req  out  1  request one snake move
apple_req  out  1  request new apple placement
halted  out  1  collision seen; steps stopped
overrun  out  1  sticky: tick arrived while a step was in progress
step_count  out  16  completed steps since run rose

Behaviour:
- Reset: all outputs 0, except dir_cur = 2'b11 (right). State IDLE, pending direction = 11, counter = TICK_DIV-1.
- States: IDLE, WAIT_TICK, MOVE, CHECK, APPLE, HALT.
- run low, from any state: next cycle go to IDLE. Clear move_req, apple_req, halted, overrun, step_count. dir_cur and pending = 11. Counter reloads base period.
- IDLE -> WAIT_TICK when run is high. Counter loads the current period.
- Period = TICK_DIV - (length_in>>SPEED_SHIFT)*SPEED_STEP, clamped to MIN_DIV if the result < MIN_DIV or the subtraction would underflow. Evaluated only at reload.
- Counter, while run is high and not HALT: decrements each cycle. At 0 it generates an internal tick and reloads period-1 in the same cycle.
- Tick in WAIT_TICK -> MOVE. dir_cur <= pending on that edge. move_req is high from the first MOVE cycle, i.e. 1 cycle after the tick.
- Tick in MOVE/CHECK/APPLE: tick dropped (not queued), overrun set (sticky until run low or Reset).
- MOVE: move_req held high until move_ack is sampled high. Then capture collision_in and ate_in, drop move_req next cycle, go to CHECK.
- CHECK (1 cycle):
  - captured collision -> HALT.
  - else ate -> APPLE.
  - else -> WAIT_TICK, step_count+1.
- APPLE: apple_req held high until apple_ack is sampled, then dropped; step_count+1; go to WAIT_TICK.
- HALT: halted=1, counter frozen, no requests. Leave only via run low.
- move_ack or apple_ack arriving outside its matching state: ignored.
- Direction filter on dir_valid: reject if dir_in[1]==dir_cur[1] and dir_in!=dir_cur (reversal vs committed direction). Otherwise pending <= dir_in. The last accepted press before a tick wins. Presses accepted in every state except IDLE/HALT. dir_cur changes only at tick commit.
- step_count wraps 16'hFFFF -> 0.
- Reset mid-step: immediate return to reset values; requests drop asynchronously.

Test Plan:
- Params TICK_DIV=8, MIN_DIV=4, SPEED_STEP=1, SPEED_SHIFT=2; length_in=3, run rises, move_ack returned 2 cycles after each req, ate=0 -> move_req rises every 8 cycles, first 9 cycles after run; step_count 1,2,3; dir_cur=11.
- length_in=12 -> period 5; length_in=40 -> period clamps to 4; spacing between move_req rises checked.
- dir_cur=11: press 10 (left, reversal) -> rejected, dir_cur stays 11 after tick. Press 00 then 01 within one tick -> dir_cur=01 at next tick.
- ate_in=1 with move_ack -> apple_req high the cycle after CHECK, held until apple_ack (delayed 5 cycles), step_count increments once.
- Hold move_ack low for 12 cycles with period 8 -> overrun=1, only one step completes, no queued second move.
- collision_in=1 -> halted=1, no further move_req; drop run -> halted=0, step_count=0, dir_cur=11. Assert Reset mid-MOVE -> move_req=0 the same cycle.
